// File: rtl/dma_tx_engine_pkg.sv
// Shared definitions for the DMA transmit engine: FSM encoding, register map
// offsets and the default configuration-space base nibble.
package dma_tx_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_LEN  = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;

    localparam logic [3:0] CFG_BASE_DEFAULT = 4'h5;
    localparam int         LEN_W            = 16;

endpackage

// File: rtl/dma_tx_engine_if.sv
// Bundles the config port, RAM read port, outbound stream and status of the engine.
// Handshakes: a RAM read completes in any cycle with m_re && m_gnt (m_rdata valid then);
// a stream word transfers in any cycle with tx_valid && tx_ready, and while tx_valid is
// high and tx_ready low the engine holds tx_valid, tx_data and tx_last unchanged.
interface dma_tx_engine_if;
    import dma_tx_engine_pkg::*;

    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_we;

    logic [31:0] m_addr;
    logic        m_re;
    logic        m_gnt;
    logic [31:0] m_rdata;

    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        tx_last;

    logic        busy;
    logic        irq_done;

    state_e      dbg_state;
    logic [7:0]  dbg_level;

    modport master (
        input  cfg_addr, cfg_wdata, cfg_we, m_gnt, m_rdata, tx_ready,
        output m_addr, m_re, tx_valid, tx_data, tx_last, busy, irq_done,
        output dbg_state, dbg_level
    );

    modport slave (
        output cfg_addr, cfg_wdata, cfg_we, m_gnt, m_rdata, tx_ready,
        input  m_addr, m_re, tx_valid, tx_data, tx_last, busy, irq_done,
        input  dbg_state, dbg_level
    );

endinterface

// File: rtl/dma_tx_fifo.sv
// Synchronous read-data FIFO; head is readable combinationally, no write-to-read bypass.
module dma_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A pop in the same cycle frees the slot being written, so push-when-full is safe then.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_tx_engine.sv
// Memory-to-stream DMA: fetches LEN words from SRC through a small FIFO and
// emits them on a valid/ready stream, flagging the final word and pulsing irq_done.
module dma_tx_engine
    import dma_tx_engine_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] CFG_BASE   = CFG_BASE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    dma_tx_engine_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    state_e           state_q, state_d;
    logic [31:0]      src_q, src_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] rem_q, rem_d;

    logic        cfg_hit, rd_fire, tx_fire, m_re;
    logic        fifo_full, fifo_empty;
    logic [32:0] fifo_head;
    logic [AW:0] fifo_count;
    logic        unused_cfg_bits;

    assign unused_cfg_bits = ^{bus.cfg_addr[27:4], bus.cfg_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        len_d   = len_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        cfg_hit = bus.cfg_we && (bus.cfg_addr[31:28] == CFG_BASE);
        m_re    = (state_q == ST_FETCH) && !fifo_full && (rem_q != '0);
        rd_fire = m_re && bus.m_gnt;
        tx_fire = !fifo_empty && bus.tx_ready;

        unique case (state_q)
            // Config registers are only writable while idle.
            ST_IDLE: begin
                if (cfg_hit) begin
                    case (bus.cfg_addr[3:2])
                        REG_SRC: src_d = {bus.cfg_wdata[31:2], 2'b00};
                        REG_LEN: len_d = bus.cfg_wdata[LEN_W-1:0];
                        REG_CTRL: begin
                            if (bus.cfg_wdata[0]) begin
                                addr_d  = src_q;
                                rem_d   = len_q;
                                state_d = (len_q == '0) ? ST_DONE : ST_FETCH;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_FETCH: begin
                if (rd_fire) begin
                    addr_d = addr_q + 32'd4;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == 1) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (tx_fire && fifo_head[32]) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // The last-word flag travels with the data so tx_last needs no output-side counter.
    dma_tx_fifo #(.DEPTH(FIFO_DEPTH), .W(33)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rd_fire),
        .wdata_i ({rem_q == 1, bus.m_rdata}),
        .pop_i   (tx_fire),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.m_re      = m_re;
    assign bus.m_addr    = addr_q;
    assign bus.tx_valid  = !fifo_empty;
    assign bus.tx_data   = fifo_empty ? 32'h0 : fifo_head[31:0];
    assign bus.tx_last   = !fifo_empty && fifo_head[32];
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.irq_done  = (state_q == ST_DONE);
    assign bus.dbg_state = state_q;
    assign bus.dbg_level = 8'(fifo_count);

endmodule
